// File: rtl/imem_responder_pkg.sv
// Shared types and helpers for the instruction-memory responder.
package imem_responder_pkg;

    // FSM encoding for the fetch responder.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Wait-state counter width; WAIT is limited to 0..15.
    localparam int CNT_W = 4;

    // Registered response presented to the fetch consumer.
    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    // A fetch is bad if it is not word aligned or lands past the last word.
    function automatic logic fetch_err(input logic [31:0] addr, input int depth_log2);
        logic [31:0] word_idx;
        word_idx = addr >> 2;
        return (addr[1:0] != 2'b00) || (word_idx >= (32'd1 << depth_log2));
    endfunction

endpackage

// File: rtl/imem_responder_array.sv
// Word-wide program storage: synchronous write, combinational read.
import imem_responder_pkg::*;

module imem_array #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [31:0]           wr_data,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [31:0]           rd_data
);

    logic [31:0] mem [2**DEPTH_LOG2];

    // Preload writes; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Read is combinational so a same-edge write returns the old word.
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/imem_responder.sv
// Fetch responder: valid/ready request in, fixed wait states, valid/ready response out.
import imem_responder_pkg::*;

module imem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int WAIT       = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_data,
    output logic                  rsp_err,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [31:0]           wr_data
);

    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'((WAIT > 0) ? WAIT - 1 : 0);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [31:0]      addr_q;
    logic [31:0]      rd_addr;
    logic [31:0]      rd_data;
    logic             accept;
    logic             load_rsp;
    rsp_t             rsp_q;

    // With no wait states the response registers straight off the request bus.
    assign rd_addr = (state == S_IDLE) ? req_addr : addr_q;

    imem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr[DEPTH_LOG2+1:2]),
        .rd_data (rd_data)
    );

    assign req_ready = (state == S_IDLE) && !flush;
    assign rsp_valid = (state == S_RESP);
    assign rsp_data  = rsp_q.data;
    assign rsp_err   = rsp_q.err;

    // Next-state, wait counter and capture strobes; flush overrides everything.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        load_rsp  = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    accept = 1'b1;
                    if (WAIT > 0) begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = WAIT_LOAD;
                    end else begin
                        state_nxt = S_RESP;
                        load_rsp  = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    state_nxt = S_RESP;
                    load_rsp  = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (flush) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
            accept    = 1'b0;
            load_rsp  = 1'b0;
        end
    end

    // State, counter and captured fetch address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            addr_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) addr_q <= req_addr;
        end
    end

    // Response word/error registered on entry to RESP and held until taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_q <= '0;
        end else if (load_rsp) begin
            if (fetch_err(rd_addr, DEPTH_LOG2)) begin
                rsp_q.data <= 32'h0000_0000;
                rsp_q.err  <= 1'b1;
            end else begin
                rsp_q.data <= rd_data;
                rsp_q.err  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: vector table + scoreboard + corner sequences.
module tb_imem_responder;

    localparam int WAIT_P = 2;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          first;
    } exp_t;

    logic        clk, rst;
    logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, flush;
    logic [31:0] req_addr, rsp_data;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;

    logic        req_valid1, req_ready1, rsp_valid1, rsp_ready1, rsp_err1, flush1;
    logic [31:0] req_addr1, rsp_data1;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   held = 1'b0;
    exp_t q[$];
    vec_t vecs[9];

    imem_responder #(.DEPTH_LOG2(10), .WAIT(WAIT_P)) u0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .flush(flush), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    imem_responder #(.DEPTH_LOG2(10), .WAIT(0)) u1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_addr(req_addr1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_data(rsp_data1), .rsp_err(rsp_err1),
        .flush(flush1), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every presented response must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst) begin
            held = 1'b0;
        end else if (rsp_valid && !flush) begin
            if (q.size() == 0) begin
                chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                if (!held) chk("latency", 32'(cyc), 32'(q[0].first));
                chk("rsp_data", rsp_data, q[0].data);
                chk("rsp_err", 32'(rsp_err), 32'(q[0].err));
                if (rsp_ready) q.delete(0);
            end
            held = !rsp_ready;
        end else begin
            held = 1'b0;
        end
    end

    task automatic wr(input logic [9:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        wr_en = 1'b1; wr_addr = a; wr_data = d;
    endtask

    task automatic send(input logic [31:0] a, input bit push, input logic [31:0] d,
                        input logic e, output int acc);
        int n;
        n = 0;
        acc = -1;
        @(posedge clk); #1;
        req_valid = 1'b1; req_addr = a;
        @(negedge clk);
        while (!req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++; failures++;
            $display("FAIL accept_timeout: addr %h never accepted", a);
            req_valid = 1'b0;
            return;
        end
        acc = cyc;
        if (push) q.push_back('{d, e, cyc + 1 + WAIT_P});
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(q.size()), 32'd0);
    endtask

    task automatic quiet(input string name);
        bit saw;
        saw = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) saw = 1'b1;
        end
        chk(name, 32'(saw), 32'd0);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("wait_rsp_valid", 32'(rsp_valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, last;

        vecs[0] = '{32'h0000_0000, 32'h0000_0013, 1'b0};
        vecs[1] = '{32'h0000_0004, 32'h0010_0093, 1'b0};
        vecs[2] = '{32'h0000_0008, 32'h0020_0113, 1'b0};
        vecs[3] = '{32'h0000_000C, 32'h0030_8193, 1'b0};
        vecs[4] = '{32'h0000_0006, 32'h0000_0000, 1'b1};
        vecs[5] = '{32'h0000_1000, 32'h0000_0000, 1'b1};
        vecs[6] = '{32'h0000_0FFC, 32'hDEAD_BEEF, 1'b0};
        vecs[7] = '{32'h0000_0003, 32'h0000_0000, 1'b1};
        vecs[8] = '{32'hFFFF_FFFC, 32'h0000_0000, 1'b1};

        rst = 1'b0; flush = 1'b0; flush1 = 1'b0;
        req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
        req_valid1 = 1'b0; req_addr1 = '0; rsp_ready1 = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_data", rsp_data, 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        @(posedge clk); #3 rst = 1'b1;
        @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'd1);

        // Program image
        wr(10'd0, 32'h0000_0013);
        wr(10'd1, 32'h0010_0093);
        wr(10'd2, 32'h0020_0113);
        wr(10'd3, 32'h0030_8193);
        wr(10'd5, 32'hA5A5_0001);
        wr(10'd1023, 32'hDEAD_BEEF);
        @(posedge clk); #1 wr_en = 1'b0;

        // Vector table, back to back with rsp_ready high
        last = 0;
        for (int i = 0; i < 9; i++) begin
            send(vecs[i].addr, 1'b1, vecs[i].data, vecs[i].err, acc);
            if (i > 0) chk("throughput", 32'(acc - last), 32'(WAIT_P + 2));
            last = acc;
        end
        drain();

        // Flush in the first wait cycle
        send(32'h4, 1'b0, 32'h0, 1'b0, acc);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        chk("post_flush_req_ready", 32'(req_ready), 32'd1);
        quiet("flush_no_rsp");
        send(32'h8, 1'b1, 32'h0020_0113, 1'b0, acc);
        drain();

        // Backpressure: hold 5 cycles in RESP
        rsp_ready = 1'b0;
        send(32'hC, 1'b1, 32'h0030_8193, 1'b0, acc);
        wait_valid();
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_valid", 32'(rsp_valid), 32'd0);
        chk("bp_release_ready", 32'(req_ready), 32'd1);
        drain();

        // WAIT=0 instance with same-edge write to the fetched word
        @(posedge clk); #1;
        req_valid1 = 1'b1; req_addr1 = 32'h14;
        wr_en = 1'b1; wr_addr = 10'd5; wr_data = 32'h5A5A_0002;
        @(negedge clk);
        chk("w0_req_ready", 32'(req_ready1), 32'd1);
        acc = cyc;
        @(posedge clk); #1;
        req_valid1 = 1'b0; wr_en = 1'b0;
        @(negedge clk);
        chk("w0_latency", 32'(cyc), 32'(acc + 1));
        chk("w0_rsp_valid", 32'(rsp_valid1), 32'd1);
        chk("w0_collision_old", rsp_data1, 32'hA5A5_0001);
        chk("w0_rsp_err", 32'(rsp_err1), 32'd0);
        @(negedge clk);
        chk("w0_idle_after", 32'(rsp_valid1), 32'd0);
        @(posedge clk); #1 req_valid1 = 1'b1;
        @(posedge clk); #1 req_valid1 = 1'b0;
        @(negedge clk);
        chk("w0_new_data", rsp_data1, 32'h5A5A_0002);

        // Reset while a response is held: outputs clear immediately
        rsp_ready = 1'b0;
        send(32'h0, 1'b1, 32'h0000_0013, 1'b0, acc);
        wait_valid();
        #2 rst = 1'b0;
        q.delete();
        #1;
        chk("async_rst_valid", 32'(rsp_valid), 32'd0);
        chk("async_rst_data", rsp_data, 32'd0);
        @(posedge clk); #3 rst = 1'b1; rsp_ready = 1'b1;
        @(negedge clk);
        chk("rst_resp_req_ready", 32'(req_ready), 32'd1);
        quiet("rst_resp_no_stale");

        // Reset during WAIT: fetch lost
        send(32'h4, 1'b0, 32'h0, 1'b0, acc);
        rst = 1'b0;
        #1 chk("rst_wait_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #3 rst = 1'b1;
        @(negedge clk);
        chk("rst_wait_req_ready", 32'(req_ready), 32'd1);
        quiet("rst_wait_no_stale");

        // Normal service after reset
        send(32'hC, 1'b1, 32'h0030_8193, 1'b0, acc);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
